// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode
// Purpose  : Registered RV32I decode stage. Accepts one instruction per cycle
//            over valid/ready, splits it into register selects, destination,
//            sign-extended immediate and opclass, and holds the result in a
//            single-entry output register for the execute stage.
// Options  : DECODE_SCOREBOARD_EN - when defined, a 32-entry busy vector
//            stalls issue on register hazards until writeback retires the
//            producing write. When undefined, hazard is tied low and the
//            writeback_* inputs are ignored.
// Ports    : clock, reset (sync, active-high)
//            instruction_valid/instruction/pc/instruction_ready : upstream
//            decode_valid/decode_ready : downstream handshake
//            rs1, rs2, rd, immediate, opclass, funct3, funct7_5,
//            writes_rd, illegal, pc_out : registered decode results
//            writeback_valid, writeback_select : register_file write retire
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decode (
  input  logic        clock,
  input  logic        reset,
  input  logic        instruction_valid,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  output logic        instruction_ready,
  output logic        decode_valid,
  input  logic        decode_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] immediate,
  output logic [3:0]  opclass,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic        writes_rd,
  output logic        illegal,
  output logic [31:0] pc_out,
  input  logic        writeback_valid,
  input  logic [4:0]  writeback_select
);

  localparam logic [3:0] C_LUI      = 4'd0;
  localparam logic [3:0] C_AUIPC    = 4'd1;
  localparam logic [3:0] C_JAL      = 4'd2;
  localparam logic [3:0] C_JALR     = 4'd3;
  localparam logic [3:0] C_BRANCH   = 4'd4;
  localparam logic [3:0] C_LOAD     = 4'd5;
  localparam logic [3:0] C_STORE    = 4'd6;
  localparam logic [3:0] C_OP_IMM   = 4'd7;
  localparam logic [3:0] C_OP       = 4'd8;
  localparam logic [3:0] C_MISC_MEM = 4'd9;
  localparam logic [3:0] C_SYSTEM   = 4'd10;
  localparam logic [3:0] C_ILLEGAL  = 4'd15;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // --------------------------------------------------------------------------
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [3:0]  w_class;
  logic [31:0] w_imm;
  logic        w_writes_rd;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_hazard;
  logic        w_accept;

  assign w_rs1 = instruction[19:15];
  assign w_rs2 = instruction[24:20];
  assign w_rd  = instruction[11:7];

  always_comb begin
    w_class = C_ILLEGAL;
    // Compressed / non-32-bit encodings fall through as illegal.
    if (instruction[1:0] == 2'b11) begin
      case (instruction[6:2])
        5'b01101: w_class = C_LUI;
        5'b00101: w_class = C_AUIPC;
        5'b11011: w_class = C_JAL;
        5'b11001: w_class = C_JALR;
        5'b11000: w_class = C_BRANCH;
        5'b00000: w_class = C_LOAD;
        5'b01000: w_class = C_STORE;
        5'b00100: w_class = C_OP_IMM;
        5'b01100: w_class = C_OP;
        5'b00011: w_class = C_MISC_MEM;
        5'b11100: w_class = C_SYSTEM;
        default:  w_class = C_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    w_imm = 32'd0;
    case (w_class)
      C_LOAD, C_OP_IMM, C_JALR, C_SYSTEM:
        w_imm = {{20{instruction[31]}}, instruction[31:20]};
      C_STORE:
        w_imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      C_BRANCH:
        w_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
      C_LUI, C_AUIPC:
        w_imm = {instruction[31:12], 12'd0};
      C_JAL:
        w_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
      default:
        w_imm = 32'd0;
    endcase
  end

  always_comb begin
    w_writes_rd = 1'b0;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    case (w_class)
      C_LUI, C_AUIPC, C_JAL:       w_writes_rd = 1'b1;
      C_JALR, C_LOAD, C_OP_IMM: begin
        w_writes_rd = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      C_OP: begin
        w_writes_rd = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      C_BRANCH, C_STORE: begin
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      default: begin
        w_writes_rd = 1'b0;
      end
    endcase
    // Writes to x0 are architecturally discarded, so never report them.
    if (w_rd == 5'd0) begin
      w_writes_rd = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Optional register scoreboard
  // --------------------------------------------------------------------------
`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_clear_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_eff;

  // Index 0 is excluded so a writeback to x0 has no effect.
  assign w_clear_mask = (writeback_valid && (writeback_select != 5'd0))
                        ? (32'd1 << writeback_select) : 32'd0;
  assign w_set_mask   = (w_accept && w_writes_rd) ? (32'd1 << w_rd) : 32'd0;
  // A bit retiring this cycle no longer blocks issue.
  assign w_busy_eff   = r_busy & ~w_clear_mask;

  assign w_hazard = (w_uses_rs1  && (w_rs1 != 5'd0) && w_busy_eff[w_rs1]) ||
                    (w_uses_rs2  && (w_rs2 != 5'd0) && w_busy_eff[w_rs2]) ||
                    (w_writes_rd && w_busy_eff[w_rd]);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= 32'd0;
    end else begin
      // Set is applied after clear so a same-cycle set wins.
      r_busy <= w_busy_eff | w_set_mask;
    end
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = writeback_valid ^ (^writeback_select) ^ w_uses_rs1 ^ w_uses_rs2;
  assign w_hazard    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Handshake and output register
  // --------------------------------------------------------------------------
  logic        r_valid;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_imm;
  logic [3:0]  r_class;
  logic [2:0]  r_funct3;
  logic        r_funct7_5;
  logic        r_writes_rd;
  logic        r_illegal;
  logic [31:0] r_pc;

  assign instruction_ready = !reset && (!r_valid || decode_ready) && !w_hazard;
  assign w_accept          = instruction_valid && instruction_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_imm       <= 32'd0;
      r_class     <= 4'd0;
      r_funct3    <= 3'd0;
      r_funct7_5  <= 1'b0;
      r_writes_rd <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= 32'd0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_imm       <= w_imm;
      r_class     <= w_class;
      r_funct3    <= instruction[14:12];
      r_funct7_5  <= instruction[30];
      r_writes_rd <= w_writes_rd;
      r_illegal   <= (w_class == C_ILLEGAL);
      r_pc        <= pc;
    end else if (r_valid && decode_ready) begin
      r_valid     <= 1'b0;
    end
  end

  assign decode_valid = r_valid;
  assign rs1          = r_rs1;
  assign rs2          = r_rs2;
  assign rd           = r_rd;
  assign immediate    = r_imm;
  assign opclass      = r_class;
  assign funct3       = r_funct3;
  assign funct7_5     = r_funct7_5;
  assign writes_rd    = r_writes_rd;
  assign illegal      = r_illegal;
  assign pc_out       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode
// Purpose  : Directed self-checking bench for instruction_decode. Scoreboard
//            scenarios are compiled only with DECODE_SCOREBOARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instruction_ready;
  logic        decode_valid;
  logic        decode_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] immediate;
  logic [3:0]  opclass;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        writes_rd;
  logic        illegal;
  logic [31:0] pc_out;
  logic        writeback_valid;
  logic [4:0]  writeback_select;

  int tests = 0;
  int fails = 0;

  instruction_decode dut (
    .clock             (clock),
    .reset             (reset),
    .instruction_valid (instruction_valid),
    .instruction       (instruction),
    .pc                (pc),
    .instruction_ready (instruction_ready),
    .decode_valid      (decode_valid),
    .decode_ready      (decode_ready),
    .rs1               (rs1),
    .rs2               (rs2),
    .rd                (rd),
    .immediate         (immediate),
    .opclass           (opclass),
    .funct3            (funct3),
    .funct7_5          (funct7_5),
    .writes_rd         (writes_rd),
    .illegal           (illegal),
    .pc_out            (pc_out),
    .writeback_valid   (writeback_valid),
    .writeback_select  (writeback_select)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instruction_valid = 1'b1; instruction = 32'h00500093;
    pc = 32'h44; decode_ready = 1'b1; writeback_valid = 1'b0; writeback_select = 5'd0;
    step(); step();
    tests++; if (instruction_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %0b want 0", instruction_ready); end
    tests++; if (decode_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", decode_valid); end
    tests++; if ({rd, rs1, rs2, immediate, opclass, pc_out, writes_rd, illegal} !== '0) begin
      fails++; $display("FAIL rst_data got rd=%0d imm=%h cls=%0d pc=%h want all 0", rd, immediate, opclass, pc_out); end
    reset = 1'b0; instruction_valid = 1'b0;
    #1;
    tests++; if (instruction_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %0b want 1", instruction_ready); end
  endtask

  task automatic test_addi();
    instruction_valid = 1'b1; instruction = 32'h00500093; pc = 32'h100; decode_ready = 1'b1;
    step();
    instruction_valid = 1'b0;
    tests++; if (decode_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got %0b want 1", decode_valid); end
    tests++; if (rd !== 5'd1 || rs1 !== 5'd0 || rs2 !== 5'd5) begin fails++; $display("FAIL addi_regs got rd=%0d rs1=%0d rs2=%0d want 1 0 5", rd, rs1, rs2); end
    tests++; if (immediate !== 32'h5) begin fails++; $display("FAIL addi_imm got %h want 00000005", immediate); end
    tests++; if (opclass !== 4'd7 || writes_rd !== 1'b1 || illegal !== 1'b0) begin fails++; $display("FAIL addi_cls got cls=%0d wr=%0b ill=%0b want 7 1 0", opclass, writes_rd, illegal); end
    tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL addi_pc got %h want 00000100", pc_out); end
    step();
    tests++; if (decode_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %0b want 0", decode_valid); end
  endtask

  task automatic test_formats();
    decode_ready = 1'b1;
    // lui x5, 0x12345
    instruction_valid = 1'b1; instruction = 32'h123452B7; pc = 32'h200;
    step();
    tests++; if (rd !== 5'd5 || immediate !== 32'h12345000 || opclass !== 4'd0 || writes_rd !== 1'b1) begin
      fails++; $display("FAIL lui got rd=%0d imm=%h cls=%0d wr=%0b want 5 12345000 0 1", rd, immediate, opclass, writes_rd); end
    // beq x0,x0,-4 back-to-back with the lui
    instruction = 32'hFE000EE3; pc = 32'h204;
    tests++; if (instruction_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %0b want 1", instruction_ready); end
    step();
    tests++; if (immediate !== 32'hFFFFFFFC || opclass !== 4'd4 || writes_rd !== 1'b0 || pc_out !== 32'h204) begin
      fails++; $display("FAIL beq got imm=%h cls=%0d wr=%0b pc=%h want fffffffc 4 0 00000204", immediate, opclass, writes_rd, pc_out); end
    // sw x2, 8(x1)
    instruction = 32'h0020A423;
    step();
    tests++; if (immediate !== 32'h8 || opclass !== 4'd6 || rs1 !== 5'd1 || rs2 !== 5'd2 || writes_rd !== 1'b0 || funct3 !== 3'd2) begin
      fails++; $display("FAIL sw got imm=%h cls=%0d rs1=%0d rs2=%0d wr=%0b f3=%0d want 8 6 1 2 0 2", immediate, opclass, rs1, rs2, writes_rd, funct3); end
    // jal x1, -8
    instruction = 32'hFF9FF0EF;
    step();
    tests++; if (immediate !== 32'hFFFFFFF8 || opclass !== 4'd2 || writes_rd !== 1'b1 || rd !== 5'd1) begin
      fails++; $display("FAIL jal got imm=%h cls=%0d wr=%0b rd=%0d want fffffff8 2 1 1", immediate, opclass, writes_rd, rd); end
    // addi x0,x0,0 : rd == 0 suppresses writes_rd
    instruction = 32'h00000013;
    step();
    tests++; if (opclass !== 4'd7 || writes_rd !== 1'b0) begin fails++; $display("FAIL nop got cls=%0d wr=%0b want 7 0", opclass, writes_rd); end
    // sub x3,x1,x2 : funct7 bit 30 set
    instruction = 32'h402081B3;
    step();
    tests++; if (opclass !== 4'd8 || funct7_5 !== 1'b1 || rd !== 5'd3 || immediate !== 32'h0) begin
      fails++; $display("FAIL sub got cls=%0d f7=%0b rd=%0d imm=%h want 8 1 3 0", opclass, funct7_5, rd, immediate); end
    // addi with bits[1:0] = 00 is illegal
    instruction = 32'h00500090;
    step();
    instruction_valid = 1'b0;
    tests++; if (illegal !== 1'b1 || opclass !== 4'd15 || writes_rd !== 1'b0 || immediate !== 32'h0) begin
      fails++; $display("FAIL low_bits got ill=%0b cls=%0d wr=%0b imm=%h want 1 15 0 0", illegal, opclass, writes_rd, immediate); end
    step();
  endtask

  task automatic test_illegal_hold();
    decode_ready = 1'b1;
    instruction_valid = 1'b1; instruction = 32'hFFFFFFFF; pc = 32'h300;
    step();
    tests++; if (illegal !== 1'b1 || opclass !== 4'd15 || writes_rd !== 1'b0 || immediate !== 32'h0 || decode_valid !== 1'b1) begin
      fails++; $display("FAIL ill got ill=%0b cls=%0d wr=%0b imm=%h v=%0b want 1 15 0 0 1", illegal, opclass, writes_rd, immediate, decode_valid); end
    decode_ready = 1'b0; instruction = 32'h00500093; pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (instruction_ready !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d] got %0b want 0", i, instruction_ready); end
      step();
      tests++; if (decode_valid !== 1'b1 || opclass !== 4'd15 || pc_out !== 32'h300 || rd !== 5'd31) begin
        fails++; $display("FAIL hold_out[%0d] got v=%0b cls=%0d pc=%h rd=%0d want 1 15 00000300 31", i, decode_valid, opclass, pc_out, rd); end
    end
    // Release: held instruction leaves and the waiting addi replaces it.
    decode_ready = 1'b1;
    step();
    instruction_valid = 1'b0;
    tests++; if (opclass !== 4'd7 || pc_out !== 32'h304) begin fails++; $display("FAIL release got cls=%0d pc=%h want 7 00000304", opclass, pc_out); end
    step();
  endtask

  task automatic test_dependency();
    decode_ready = 1'b1; writeback_valid = 1'b0; writeback_select = 5'd0;
    instruction_valid = 1'b1; instruction = 32'h00500093; pc = 32'h400;
    step();
    instruction = 32'h00108133; pc = 32'h404;
    #1;
`ifdef DECODE_SCOREBOARD_EN
    tests++; if (instruction_ready !== 1'b0) begin fails++; $display("FAIL raw_stall got %0b want 0", instruction_ready); end
    // Writeback to x0 must not release anything.
    writeback_valid = 1'b1; writeback_select = 5'd0;
    step();
    tests++; if (instruction_ready !== 1'b0 || decode_valid !== 1'b0) begin
      fails++; $display("FAIL wb_x0 got rdy=%0b v=%0b want 0 0", instruction_ready, decode_valid); end
    writeback_select = 5'd1;
    #1;
    tests++; if (instruction_ready !== 1'b1) begin fails++; $display("FAIL wb_bypass got %0b want 1", instruction_ready); end
    step();
    writeback_valid = 1'b0; writeback_select = 5'd0;
`else
    tests++; if (instruction_ready !== 1'b1) begin fails++; $display("FAIL no_sb_ready got %0b want 1", instruction_ready); end
    step();
`endif
    instruction_valid = 1'b0;
    tests++; if (decode_valid !== 1'b1 || rd !== 5'd2 || opclass !== 4'd8 || pc_out !== 32'h404) begin
      fails++; $display("FAIL dep_accept got v=%0b rd=%0d cls=%0d pc=%h want 1 2 8 00000404", decode_valid, rd, opclass, pc_out); end
`ifdef DECODE_SCOREBOARD_EN
    // x2 now busy: an instruction writing x2 stalls on WAW.
    instruction_valid = 1'b1; instruction = 32'h00700113;
    #1;
    tests++; if (instruction_ready !== 1'b0) begin fails++; $display("FAIL waw_stall got %0b want 0", instruction_ready); end
    writeback_valid = 1'b1; writeback_select = 5'd2;
    step();
    writeback_valid = 1'b0; instruction_valid = 1'b0;
    tests++; if (immediate !== 32'h7 || rd !== 5'd2) begin fails++; $display("FAIL waw_accept got imm=%h rd=%0d want 7 2", immediate, rd); end
`endif
    step();
  endtask

  task automatic test_reset_midflight();
    decode_ready = 1'b0; writeback_valid = 1'b0;
    instruction_valid = 1'b1; instruction = 32'h00500093; pc = 32'h500;
    step();
    instruction_valid = 1'b0;
    tests++; if (decode_valid !== 1'b1) begin fails++; $display("FAIL mid_held got %0b want 1", decode_valid); end
    reset = 1'b1;
    step();
    tests++; if (decode_valid !== 1'b0 || pc_out !== 32'h0 || immediate !== 32'h0) begin
      fails++; $display("FAIL mid_rst got v=%0b pc=%h imm=%h want 0 0 0", decode_valid, pc_out, immediate); end
    reset = 1'b0; decode_ready = 1'b1;
    instruction_valid = 1'b1; instruction = 32'h00108133; pc = 32'h504;
    #1;
    tests++; if (instruction_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %0b want 1", instruction_ready); end
    step();
    instruction_valid = 1'b0;
    tests++; if (decode_valid !== 1'b1 || rd !== 5'd2 || pc_out !== 32'h504) begin
      fails++; $display("FAIL mid_accept got v=%0b rd=%0d pc=%h want 1 2 00000504", decode_valid, rd, pc_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_illegal_hold();
    test_dependency();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
